pipe_reduce: RTL and testbench

Parametrised, fully pipelined bitwise reduction tree with a valid pipeline and a run-time selectable operator (XOR/AND/OR). Data is folded in groups of LEAF bits per register stage, and multi-beat packets are accumulated into a single result bit. It sits on datapath checkers: parity/ECC summaries, all-ones/any-set detectors. It replaces free-running reduction trees that have no valid, no reset and only zero padding.

---
 rtl/pipe_reduce_pkg.sv | 50 +++++
 rtl/pipe_reduce_if.sv | 22 ++
 rtl/pipe_reduce_level.sv | 52 +++++
 rtl/pipe_reduce.sv | 112 +++++++++++
 tb/tb_pipe_reduce.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_reduce_pkg.sv
// Shared types and helpers for the pipelined reduction tree: operator
// encoding, per-operator identity/combine, and tree geometry.
package pipe_reduce_pkg;

    typedef enum logic [1:0] {
        OP_XOR  = 2'd0,
        OP_AND  = 2'd1,
        OP_OR   = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } acc_state_e;

    // Neutral element used to pad short groups; reserved folds like XOR.
    function automatic logic identity(input op_e op);
        return (op == OP_AND);
    endfunction

    function automatic logic combine(input op_e op, input logic a, input logic b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic int levels(input int width, input int leaf);
        int l;
        int w;
        l = 1;
        w = width;
        while (w > leaf) begin
            w = (w + leaf - 1) / leaf;
            l++;
        end
        return l;
    endfunction

    // Bit count entering level k (k = 0 is the raw input).
    function automatic int level_width(input int width, input int leaf, input int k);
        int w;
        w = width;
        for (int i = 0; i < k; i++) w = (w + leaf - 1) / leaf;
        return w;
    endfunction

endpackage

// File: rtl/pipe_reduce_if.sv
// Beat input / packet result bundle for pipe_reduce.
interface pipe_reduce_if #(
    parameter int WIDTH = 10
);
    logic             in_valid;
    logic [1:0]       in_op;
    logic             in_last;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [1:0]       out_op;
    logic             out_res;

    modport master (
        output in_valid, in_op, in_last, in_data,
        input  out_valid, out_op, out_res
    );

    modport slave (
        input  in_valid, in_op, in_last, in_data,
        output out_valid, out_op, out_res
    );
endinterface

// File: rtl/pipe_reduce_level.sv
// One registered tree level: folds LEAF-bit groups into one bit each and
// carries the valid/op/last sideband alongside.
module pipe_reduce_level
    import pipe_reduce_pkg::*;
#(
    parameter  int IN_W  = 10,
    parameter  int LEAF  = 6,
    localparam int OUT_W = (IN_W + LEAF - 1) / LEAF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  op_e              in_op,
    input  logic             in_last,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_vld,
    output op_e              out_op,
    output logic             out_last,
    output logic [OUT_W-1:0] out_data
);

    logic [OUT_W*LEAF-1:0] padded;
    logic [OUT_W-1:0]      grp_res;

    // Pad with the beat's own identity so the short group cannot bias AND.
    always_comb begin
        padded             = {(OUT_W*LEAF){identity(in_op)}};
        padded[IN_W-1:0]   = in_data;
    end

    for (genvar g = 0; g < OUT_W; g++) begin : g_grp
        logic [LEAF-1:0] grp;
        assign grp        = padded[g*LEAF +: LEAF];
        assign grp_res[g] = (in_op == OP_AND) ? (&grp) :
                            (in_op == OP_OR)  ? (|grp) : (^grp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_op   <= OP_XOR;
            out_last <= 1'b0;
            out_data <= '0;
        end else begin
            out_vld  <= in_vld;
            out_op   <= in_vld ? in_op : OP_XOR;
            out_last <= in_vld & in_last;
            out_data <= grp_res;
        end
    end

endmodule

// File: rtl/pipe_reduce.sv
// Pipelined reduction tree plus packet accumulator; one result bit per
// packet, LAT = levels(WIDTH, LEAF) + 1 cycles after the last beat.
module pipe_reduce
    import pipe_reduce_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int LEAF  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_reduce_if.slave  bus
);

    localparam int L = levels(WIDTH, LEAF);

    logic [L:0] vld_pipe;
    logic [L:0] last_pipe;
    op_e        op_pipe [L+1];

    assign vld_pipe[0]  = bus.in_valid;
    assign last_pipe[0] = bus.in_last;
    assign op_pipe[0]   = op_e'(bus.in_op);

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int IW = level_width(WIDTH, LEAF, k);
        localparam int OW = level_width(WIDTH, LEAF, k + 1);
        logic [IW-1:0] d_in;
        logic [OW-1:0] d_out;

        if (k == 0) begin : g_src
            assign d_in = bus.in_data;
        end else begin : g_chain
            assign d_in = g_lvl[k-1].d_out;
        end

        pipe_reduce_level #(.IN_W(IW), .LEAF(LEAF)) u_level (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_vld   (vld_pipe[k]),
            .in_op    (op_pipe[k]),
            .in_last  (last_pipe[k]),
            .in_data  (d_in),
            .out_vld  (vld_pipe[k+1]),
            .out_op   (op_pipe[k+1]),
            .out_last (last_pipe[k+1]),
            .out_data (d_out)
        );
    end

    logic tree_vld, tree_last, tree_res;
    op_e  tree_op;

    assign tree_vld  = vld_pipe[L];
    assign tree_last = last_pipe[L];
    assign tree_op   = op_pipe[L];
    assign tree_res  = g_lvl[L-1].d_out[0];

    acc_state_e state, state_nxt;
    logic       acc;
    op_e        acc_op;
    logic       acc_load, emit, fold_res;
    op_e        fold_op;
    logic       out_valid_q, out_res_q;
    op_e        out_op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (tree_vld && !tree_last) state_nxt = ST_ACC;
            ST_ACC:  if (tree_vld &&  tree_last) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // In ACC the latched first-beat op governs; later beat ops are ignored.
    always_comb begin
        acc_load = tree_vld & ~tree_last;
        emit     = tree_vld &  tree_last;
        fold_op  = (state == ST_ACC) ? acc_op : tree_op;
        fold_res = (state == ST_ACC) ? combine(acc_op, acc, tree_res) : tree_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= 1'b0;
            acc_op      <= OP_XOR;
            out_valid_q <= 1'b0;
            out_res_q   <= 1'b0;
            out_op_q    <= OP_XOR;
        end else begin
            out_valid_q <= emit;
            if (acc_load) begin
                acc    <= fold_res;
                acc_op <= fold_op;
            end
            if (emit) begin
                out_res_q <= fold_res;
                out_op_q  <= fold_op;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_res   = out_res_q;
    assign bus.out_op    = out_op_q;

endmodule

// File: tb/tb_pipe_reduce.sv
// Directed vectors and multi-cycle sequences on a 10-bit/LEAF-6 instance,
// plus random packets on a WIDTH x LEAF sweep against a bit-count model.
module tb_pipe_reduce;

    typedef struct {
        logic [1:0] op;
        logic [9:0] data;
        logic       exp_res;
    } vec_t;

    typedef struct {
        logic       res;
        logic [1:0] op;
        int         cyc;
    } pulse_t;

    function automatic int sw_width(input int i);
        case (i)
            0: return 1;
            1: return 6;
            2: return 7;
            3: return 36;
            4: return 37;
            default: return 64;
        endcase
    endfunction

    // Tree depth straight from its definition: repeated ceil-division.
    function automatic int ref_levels(input int w, input int leaf);
        int n;
        int x;
        n = 0;
        x = w;
        do begin
            x = (x + leaf - 1) / leaf;
            n++;
        end while (x > 1);
        return n;
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    bit   sweep_go = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed instance ----------------
    pipe_reduce_if #(.WIDTH(10)) dbus ();
    pipe_reduce #(.WIDTH(10), .LEAF(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dbus)
    );

    pulse_t mon_q[$];
    always @(negedge clk) begin
        if (dbus.out_valid) mon_q.push_back('{dbus.out_res, dbus.out_op, cyc});
    end

    task automatic drive(input logic v, input logic [1:0] op, input logic last, input logic [9:0] d);
        @(posedge clk);
        #1;
        dbus.in_valid = v;
        dbus.in_op    = op;
        dbus.in_last  = last;
        dbus.in_data  = d;
    endtask

    vec_t vecs[8];
    int   c0;

    initial begin
        vecs[0] = '{2'd0, 10'h3FF, 1'b0};
        vecs[1] = '{2'd0, 10'h001, 1'b1};
        vecs[2] = '{2'd1, 10'h3FF, 1'b1};
        vecs[3] = '{2'd1, 10'h3FE, 1'b0};
        vecs[4] = '{2'd2, 10'h000, 1'b0};
        vecs[5] = '{2'd2, 10'h200, 1'b1};
        vecs[6] = '{2'd0, 10'h155, 1'b1};
        vecs[7] = '{2'd3, 10'h007, 1'b1};

        dbus.in_valid = 1'b0;
        dbus.in_op    = 2'd0;
        dbus.in_last  = 1'b0;
        dbus.in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {31'd0, dbus.out_valid}, 0);
        check("reset_out_res",   {31'd0, dbus.out_res}, 0);
        check("reset_out_op",    {30'd0, dbus.out_op}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            mon_q.delete();
            drive(1'b1, vecs[i].op, 1'b1, vecs[i].data);
            c0 = cyc;
            drive(1'b0, 2'd0, 1'b0, 10'h0);
            repeat (6) @(posedge clk);
            #1;
            check($sformatf("vec%0d_pulses", i), mon_q.size(), 1);
            if (mon_q.size() > 0) begin
                check($sformatf("vec%0d_res", i), {31'd0, mon_q[0].res}, {31'd0, vecs[i].exp_res});
                check($sformatf("vec%0d_op", i), {30'd0, mon_q[0].op}, {30'd0, vecs[i].op});
                check($sformatf("vec%0d_latency", i), mon_q[0].cyc - c0, 3);
            end
        end

        // OR packet of three beats with idle gaps between them
        mon_q.delete();
        drive(1'b1, 2'd2, 1'b0, 10'h000);
        drive(1'b0, 2'd0, 1'b0, 10'h3FF);
        drive(1'b0, 2'd0, 1'b1, 10'h3FF);
        drive(1'b1, 2'd2, 1'b0, 10'h000);
        drive(1'b0, 2'd0, 1'b0, 10'h000);
        drive(1'b1, 2'd2, 1'b1, 10'h200);
        c0 = cyc;
        drive(1'b0, 2'd0, 1'b0, 10'h000);
        repeat (6) @(posedge clk);
        #1;
        check("gap_pulses", mon_q.size(), 1);
        if (mon_q.size() > 0) begin
            check("gap_res", {31'd0, mon_q[0].res}, 1);
            check("gap_op", {30'd0, mon_q[0].op}, 2);
            check("gap_latency", mon_q[0].cyc - c0, 3);
        end

        // back-to-back single-beat packets
        mon_q.delete();
        drive(1'b1, 2'd0, 1'b1, 10'h001);
        c0 = cyc;
        drive(1'b1, 2'd1, 1'b1, 10'h0FF);
        drive(1'b0, 2'd0, 1'b0, 10'h000);
        repeat (6) @(posedge clk);
        #1;
        check("b2b_pulses", mon_q.size(), 2);
        if (mon_q.size() == 2) begin
            check("b2b_res0", {31'd0, mon_q[0].res}, 1);
            check("b2b_op0",  {30'd0, mon_q[0].op}, 0);
            check("b2b_cyc0", mon_q[0].cyc - c0, 3);
            check("b2b_res1", {31'd0, mon_q[1].res}, 0);
            check("b2b_op1",  {30'd0, mon_q[1].op}, 1);
            check("b2b_cyc1", mon_q[1].cyc - c0, 4);
        end

        // leave non-zero outputs, then reset in the middle of a packet
        drive(1'b1, 2'd1, 1'b1, 10'h3FF);
        drive(1'b0, 2'd0, 1'b0, 10'h000);
        repeat (5) @(posedge clk);
        mon_q.delete();
        drive(1'b1, 2'd0, 1'b0, 10'h001);
        drive(1'b1, 2'd0, 1'b0, 10'h000);
        drive(1'b0, 2'd0, 1'b0, 10'h000);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", {31'd0, dbus.out_valid}, 0);
        check("rst_mid_out_res",   {31'd0, dbus.out_res}, 0);
        check("rst_mid_out_op",    {30'd0, dbus.out_op}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 2'd0, 1'b1, 10'h003);
        c0 = cyc;
        drive(1'b0, 2'd0, 1'b0, 10'h000);
        repeat (8) @(posedge clk);
        #1;
        check("rst_pulses", mon_q.size(), 1);
        if (mon_q.size() > 0) begin
            check("rst_res", {31'd0, mon_q[0].res}, 0);
            check("rst_latency", mon_q[0].cyc - c0, 3);
        end

        sweep_go = 1'b1;
        for (int t = 0; t < 30000 && done_cnt < 12; t++) @(posedge clk);
        check("sweep_done", done_cnt, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- randomized sweep ----------------
    for (genvar i = 0; i < 12; i++) begin : g_sw
        localparam int W   = sw_width(i / 2);
        localparam int LF  = (i % 2 == 0) ? 4 : 6;
        localparam int LAT = ref_levels(W, LF) + 1;

        pipe_reduce_if #(.WIDTH(W)) sbus ();
        pipe_reduce #(.WIDTH(W), .LEAF(LF)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sbus)
        );

        pulse_t exp_q[$];
        pulse_t got;

        always @(negedge clk) begin
            if (sbus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("sw_w%0d_l%0d_unexpected", W, LF), 1, 0);
                end else begin
                    got = exp_q.pop_front();
                    check($sformatf("sw_w%0d_l%0d_res", W, LF), {31'd0, sbus.out_res}, {31'd0, got.res});
                    check($sformatf("sw_w%0d_l%0d_op", W, LF), {30'd0, sbus.out_op}, {30'd0, got.op});
                    check($sformatf("sw_w%0d_l%0d_latency", W, LF), cyc, got.cyc);
                end
            end
        end

        initial begin
            logic [W-1:0] d;
            logic [1:0]   op;
            logic         res;
            int           nb, ones, gap;
            sbus.in_valid = 1'b0;
            sbus.in_op    = 2'd0;
            sbus.in_last  = 1'b0;
            sbus.in_data  = '0;
            wait (sweep_go);
            for (int p = 0; p < 40; p++) begin
                nb   = $urandom_range(1, 4);
                op   = 2'($urandom_range(0, 3));
                ones = 0;
                for (int b = 0; b < nb; b++) begin
                    case ($urandom_range(0, 3))
                        0: d = W'({$urandom(), $urandom()});
                        1: d = '1;
                        2: d = '0;
                        default: begin
                            d = '0;
                            d[$urandom_range(0, W - 1)] = 1'b1;
                        end
                    endcase
                    ones += $countones(d);
                    @(posedge clk);
                    #1;
                    sbus.in_valid = 1'b1;
                    sbus.in_op    = op;
                    sbus.in_last  = (b == nb - 1);
                    sbus.in_data  = d;
                    if (b == nb - 1) begin
                        case (op)
                            2'd1:    res = (ones == nb * W);
                            2'd2:    res = (ones != 0);
                            default: res = ones[0];
                        endcase
                        exp_q.push_back('{res, op, cyc + LAT});
                    end
                    if ($urandom_range(0, 1) == 1) begin
                        gap = $urandom_range(1, 2);
                        repeat (gap) begin
                            @(posedge clk);
                            #1;
                            sbus.in_valid = 1'b0;
                            sbus.in_op    = 2'($urandom_range(0, 3));
                            sbus.in_last  = 1'($urandom_range(0, 1));
                            sbus.in_data  = W'({$urandom(), $urandom()});
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            sbus.in_valid = 1'b0;
            sbus.in_last  = 1'b0;
            repeat (LAT + 4) @(posedge clk);
            check($sformatf("sw_w%0d_l%0d_drain", W, LF), exp_q.size(), 0);
            done_cnt++;
        end
    end

endmodule
